// File: rtl/bscan_pkg.sv
// Shared constants and the synchronized-input bundle for the BSCAN debug-register endpoint.
package bscan_pkg;

  localparam logic [31:0]  BSCANID_DEFAULT = 32'h0490_0101;
  localparam int unsigned  SYNC_STAGES_MIN = 2;
  localparam int unsigned  SYNC_STAGES_MAX = 4;
  localparam int unsigned  DR_WIDTH_MIN    = 8;
  localparam int unsigned  DR_WIDTH_MAX    = 64;

  // Synchronized copies of the BSCAN inputs that the endpoint actually uses
  typedef struct packed {
    logic reset;
    logic sel;
    logic capture;
    logic shift;
    logic update;
    logic tdi;
    logic tck;
    logic bscanid_en;
  } bscan_sync_t;

  localparam int unsigned SYNC_BITS = $bits(bscan_sync_t);

endpackage

// File: rtl/bscan_dr_sampler_if.sv
// BSCAN port bundle plus the fabric-side capture/update handshake.
interface bscan_dr_sampler_if #(
  parameter int unsigned C_DR_WIDTH = 32
);
  logic                  s_drck;
  logic                  s_reset;
  logic                  s_sel;
  logic                  s_capture;
  logic                  s_shift;
  logic                  s_update;
  logic                  s_tdi;
  logic                  s_runtest;
  logic                  s_tck;
  logic                  s_tms;
  logic                  s_bscanid_en;
  logic                  s_tdo;
  logic [31:0]           s_bscanid;
  logic [C_DR_WIDTH-1:0] cap_data;
  logic [C_DR_WIDTH-1:0] upd_data;
  logic                  upd_valid;
  logic                  upd_ready;
  logic                  overrun;

  modport master (
    output s_drck, s_reset, s_sel, s_capture, s_shift, s_update, s_tdi,
           s_runtest, s_tck, s_tms, s_bscanid_en, cap_data, upd_ready,
    input  s_tdo, s_bscanid, upd_data, upd_valid, overrun
  );

  modport slave (
    input  s_drck, s_reset, s_sel, s_capture, s_shift, s_update, s_tdi,
           s_runtest, s_tck, s_tms, s_bscanid_en, cap_data, upd_ready,
    output s_tdo, s_bscanid, upd_data, upd_valid, overrun
  );
endinterface

// File: rtl/bscan_sync_bit.sv
// Single-bit flop-chain synchronizer with async active-low reset.
module bscan_sync_bit #(
  parameter int unsigned C_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [C_STAGES-1:0] sync_q;
  logic [C_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[C_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[C_STAGES-1];

endmodule

// File: rtl/bscan_dr_sampler.sv
// Fabric-clocked JTAG user data register: oversampled capture/shift/update with a
// valid/ready update port and a sticky overrun flag.
module bscan_dr_sampler
  import bscan_pkg::*;
#(
  parameter int unsigned C_DR_WIDTH    = 32,
  parameter logic [31:0] C_BSCANID     = BSCANID_DEFAULT,
  parameter int unsigned C_SYNC_STAGES = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  bscan_dr_sampler_if.slave bus
);

  localparam logic [C_DR_WIDTH-1:0] ID_DR = C_DR_WIDTH'(C_BSCANID);

  logic [SYNC_BITS-1:0] sync_in;
  logic [SYNC_BITS-1:0] sync_out;
  bscan_sync_t          s;

  assign sync_in = {bus.s_reset, bus.s_sel, bus.s_capture, bus.s_shift,
                    bus.s_update, bus.s_tdi, bus.s_tck, bus.s_bscanid_en};
  assign s       = bscan_sync_t'(sync_out);

  for (genvar i = 0; i < int'(SYNC_BITS); i++) begin : g_sync
    bscan_sync_bit #(.C_STAGES(C_SYNC_STAGES)) u_sync (
      .clk   (aclk),
      .rst_n (aresetn),
      .d     (sync_in[i]),
      .q     (sync_out[i])
    );
  end

  // Pins present on the BSCAN primitive that this endpoint never needs
  logic unused_inputs_c;
  assign unused_inputs_c = bus.s_drck ^ bus.s_runtest ^ bus.s_tms;

  logic                  tck_prev_q,     tck_prev_d;
  logic                  upd_sel_prev_q, upd_sel_prev_d;
  logic [C_DR_WIDTH-1:0] sr_q,           sr_d;
  logic                  tdo_q,          tdo_d;
  logic [C_DR_WIDTH-1:0] upd_data_q,     upd_data_d;
  logic                  upd_valid_q,    upd_valid_d;
  logic                  overrun_q,      overrun_d;

  logic tck_rise_c, tck_fall_c, upd_sel_c, upd_event_c;

  always_comb begin
    tck_rise_c     = s.tck & ~tck_prev_q;
    tck_fall_c     = ~s.tck & tck_prev_q;
    upd_sel_c      = s.update & s.sel;
    upd_event_c    = upd_sel_c & ~upd_sel_prev_q & ~s.bscanid_en;

    tck_prev_d     = s.tck;
    upd_sel_prev_d = upd_sel_c;
    sr_d           = sr_q;
    tdo_d          = tdo_q;
    upd_data_d     = upd_data_q;
    upd_valid_d    = upd_valid_q;
    overrun_d      = overrun_q;

    // Test-logic reset wipes only the JTAG-side register, never the fabric side
    if (s.reset) begin
      sr_d  = '0;
      tdo_d = 1'b0;
    end else begin
      if (tck_rise_c && s.sel) begin
        if (s.capture)    sr_d = s.bscanid_en ? ID_DR : bus.cap_data;
        else if (s.shift) sr_d = {s.tdi, sr_q[C_DR_WIDTH-1:1]};
      end
      if (tck_fall_c) tdo_d = sr_q[0];
    end

    // A new update may reuse the slot being handed off in the same cycle
    if (upd_event_c) begin
      if (!upd_valid_q || bus.upd_ready) begin
        upd_data_d  = sr_q;
        upd_valid_d = 1'b1;
      end else begin
        overrun_d   = 1'b1;
      end
    end else if (upd_valid_q && bus.upd_ready) begin
      upd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tck_prev_q     <= 1'b0;
      upd_sel_prev_q <= 1'b0;
      sr_q           <= '0;
      tdo_q          <= 1'b0;
      upd_data_q     <= '0;
      upd_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      tck_prev_q     <= tck_prev_d;
      upd_sel_prev_q <= upd_sel_prev_d;
      sr_q           <= sr_d;
      tdo_q          <= tdo_d;
      upd_data_q     <= upd_data_d;
      upd_valid_q    <= upd_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.s_tdo     = tdo_q;
  assign bus.s_bscanid = C_BSCANID;
  assign bus.upd_data  = upd_data_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_bscan_dr_sampler.sv
// Directed bench for bscan_dr_sampler: TCK = aclk/8, hand-computed expected values.
module tb_bscan_dr_sampler;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] dout;

  bscan_dr_sampler_if #(.C_DR_WIDTH(32)) bus ();

  bscan_dr_sampler #(
    .C_DR_WIDTH    (32),
    .C_BSCANID     (32'h0490_0101),
    .C_SYNC_STAGES (2)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic tck_cycle();
    bus.s_tck = 1'b1;
    wait_neg(4);
    bus.s_tck = 1'b0;
    wait_neg(4);
  endtask

  task automatic jtag_capture();
    bus.s_capture = 1'b1;
    tck_cycle();
    bus.s_capture = 1'b0;
  endtask

  // TDO is read just before each TCK rise, as a JTAG host samples it
  task automatic jtag_shift(input int n, input logic [31:0] din, output logic [31:0] dq);
    dq = '0;
    bus.s_shift = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.s_tdi = din[i];
      dq[i]     = bus.s_tdo;
      tck_cycle();
    end
    bus.s_shift = 1'b0;
  endtask

  task automatic jtag_update();
    bus.s_update = 1'b1;
    tck_cycle();
    bus.s_update = 1'b0;
    wait_neg(2);
  endtask

  initial begin
    bus.s_drck = 1'b0; bus.s_reset = 1'b0; bus.s_sel = 1'b0;
    bus.s_capture = 1'b0; bus.s_shift = 1'b0; bus.s_update = 1'b0;
    bus.s_tdi = 1'b0; bus.s_runtest = 1'b0; bus.s_tck = 1'b0;
    bus.s_tms = 1'b0; bus.s_bscanid_en = 1'b0;
    bus.cap_data = '0; bus.upd_ready = 1'b0;

    #2 aresetn = 1'b0;
    wait_neg(3);
    check("rst_tdo",       64'(bus.s_tdo),     64'h0);
    check("rst_upd_data",  64'(bus.upd_data),  64'h0);
    check("rst_upd_valid", 64'(bus.upd_valid), 64'h0);
    check("rst_overrun",   64'(bus.overrun),   64'h0);
    check("bscanid",       64'(bus.s_bscanid), 64'h0490_0101);
    aresetn = 1'b1;
    wait_neg(4);

    // Capture status word and read it out while shifting a new value in
    bus.s_sel    = 1'b1;
    bus.cap_data = 32'hDEAD_BEEF;
    jtag_capture();
    jtag_shift(32, 32'h1234_5678, dout);
    check("cap_shift_out", 64'(dout), 64'hDEAD_BEEF);

    // Update latency: valid appears on the third aclk edge after UPDATE rises
    bus.s_update = 1'b1;
    @(posedge aclk); #1 check("upd_lat1", 64'(bus.upd_valid), 64'h0);
    @(posedge aclk); #1 check("upd_lat2", 64'(bus.upd_valid), 64'h0);
    @(posedge aclk); #1 check("upd_lat3", 64'(bus.upd_valid), 64'h1);
    check("upd_data", 64'(bus.upd_data), 64'h1234_5678);
    wait_neg(6);
    bus.s_update = 1'b0;
    wait_neg(4);
    check("upd_hold", 64'(bus.upd_valid), 64'h1);
    bus.upd_ready = 1'b1;
    @(posedge aclk); #1 check("upd_drain", 64'(bus.upd_valid), 64'h0);
    @(negedge aclk);
    bus.upd_ready = 1'b0;

    // Overrun: second update dropped while the first is still pending
    jtag_shift(32, 32'h0000_00A5, dout);
    jtag_update();
    check("ovr_first_valid", 64'(bus.upd_valid), 64'h1);
    check("ovr_first_data",  64'(bus.upd_data),  64'hA5);
    jtag_shift(32, 32'h0000_005A, dout);
    jtag_update();
    check("ovr_keep_data", 64'(bus.upd_data), 64'hA5);
    check("ovr_flag",      64'(bus.overrun),  64'h1);

    // Ready coincides with a third update: slot is handed off and refilled
    jtag_shift(32, 32'h0000_003C, dout);
    bus.s_update = 1'b1;
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    bus.upd_ready = 1'b1;
    @(posedge aclk); #1;
    check("simul_valid", 64'(bus.upd_valid), 64'h1);
    check("simul_data",  64'(bus.upd_data),  64'h3C);
    @(negedge aclk);
    bus.upd_ready = 1'b0;
    wait_neg(8);
    bus.s_update = 1'b0;
    wait_neg(4);
    check("ovr_sticky", 64'(bus.overrun), 64'h1);
    bus.upd_ready = 1'b1;
    @(posedge aclk); #1 check("simul_drain", 64'(bus.upd_valid), 64'h0);
    @(negedge aclk);
    bus.upd_ready = 1'b0;

    // ID mode: capture yields the ID constant and UPDATE is ignored
    bus.s_bscanid_en = 1'b1;
    jtag_capture();
    jtag_shift(32, 32'hFFFF_FFFF, dout);
    check("id_shift_out", 64'(dout), 64'h0490_0101);
    jtag_update();
    wait_neg(4);
    check("id_no_update", 64'(bus.upd_valid), 64'h0);
    bus.s_bscanid_en = 1'b0;
    wait_neg(4);

    // JTAG reset mid-shift clears the DR but leaves a pending update alone
    jtag_shift(32, 32'h0000_0077, dout);
    jtag_update();
    check("jr_pending", 64'(bus.upd_valid), 64'h1);
    bus.cap_data = 32'hFFFF_FFFF;
    jtag_capture();
    jtag_shift(8, 32'h0, dout);
    check("jr_partial", 64'(dout), 64'hFF);
    bus.s_reset = 1'b1;
    wait_neg(8);
    bus.s_reset = 1'b0;
    wait_neg(4);
    check("jr_tdo_zero", 64'(bus.s_tdo), 64'h0);
    jtag_shift(16, 32'h0000_FFFF, dout);
    check("jr_shift_zero",  64'(dout),          64'h0);
    check("jr_valid_kept",  64'(bus.upd_valid), 64'h1);
    check("jr_data_kept",   64'(bus.upd_data),  64'h77);
    bus.cap_data = 32'hCAFE_F00D;
    jtag_capture();
    jtag_shift(32, 32'h0, dout);
    check("jr_recapture", 64'(dout), 64'hCAFE_F00D);

    // Async reset mid-shift clears everything immediately
    bus.cap_data = 32'hFFFF_FFFF;
    jtag_capture();
    jtag_shift(5, 32'h0, dout);
    aresetn = 1'b0;
    #1;
    check("ar_tdo",       64'(bus.s_tdo),     64'h0);
    check("ar_upd_valid", 64'(bus.upd_valid), 64'h0);
    check("ar_upd_data",  64'(bus.upd_data),  64'h0);
    check("ar_overrun",   64'(bus.overrun),   64'h0);
    wait_neg(3);
    aresetn = 1'b1;
    wait_neg(4);
    bus.cap_data = 32'h0F0F_0F0F;
    jtag_capture();
    jtag_shift(32, 32'h0, dout);
    check("ar_restart", 64'(dout), 64'h0F0F_0F0F);
    check("bscanid_end", 64'(bus.s_bscanid), 64'h0490_0101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
